// File: rtl/freq_gauge_sched_pkg.sv
// Shared types and register-map constants for the frequency-gauge scheduler.
// Optional feature macro: FREQ_GAUGE_SCHED_IRQ_EN (adds irq output and CTRL.irq_en).
package freq_gauge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    STORE  = 3'd5
  } state_e;

  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // Counter/index width for a limit, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/freq_gauge_sched_regs.sv
// Avalon-MM register file: RESULT[i], CTRL and STATUS storage plus the read mux.
// Optional feature macro: FREQ_GAUGE_SCHED_IRQ_EN (irq level and CTRL.irq_en).
module freq_gauge_sched_regs
  import freq_gauge_sched_pkg::*;
#(
  parameter int NumProbes = 4,
  localparam int AW = $clog2(NumProbes + 2),
  localparam int IW = cnt_w(NumProbes)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_address,
  input  logic          i_read,
  output logic [31:0]   o_readdata,
  input  logic          i_write,
  input  logic [31:0]   i_writedata,
  input  logic          i_store,
  input  logic          i_store_ok,
  input  logic          i_store_last,
  input  logic [IW-1:0] i_store_idx,
  input  logic [31:0]   i_store_count,
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
  output logic          o_irq,
`endif
  output logic          o_run
);

  localparam logic [AW-1:0] CtrlAddr = AW'(NumProbes + CTRL_OFS);
  localparam logic [AW-1:0] StatAddr = AW'(NumProbes + STATUS_OFS);

  logic [31:0]          r_result [NumProbes];
  logic [NumProbes-1:0] r_valid;
  logic [NumProbes-1:0] r_tmo;
  logic                 r_run;
  logic [31:0]          r_readdata;
  logic                 w_ctrl_wr;
  logic                 w_clr;
  logic [NumProbes-1:0] w_valid_nxt;
  logic [NumProbes-1:0] w_tmo_nxt;
  logic [31:0]          w_ctrl;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_ctrl_wr = i_write && (i_address == CtrlAddr);
  assign w_clr     = w_ctrl_wr && i_writedata[CTRL_CLR_BIT];

  // A STORE lands after the clear so its own probe bit wins a same-cycle clear.
  always_comb begin
    w_valid_nxt = w_clr ? '0 : r_valid;
    w_tmo_nxt   = w_clr ? '0 : r_tmo;
    if (i_store) begin
      w_valid_nxt[i_store_idx] = i_store_ok;
      w_tmo_nxt[i_store_idx]   = ~i_store_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumProbes; i++) r_result[i] <= '0;
      r_valid <= '0;
      r_tmo   <= '0;
      r_run   <= 1'b1;
    end else begin
      if (i_store) r_result[i_store_idx] <= i_store_ok ? i_store_count : '0;
      r_valid <= w_valid_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_ctrl_wr) r_run <= i_writedata[CTRL_RUN_BIT];
    end
  end

`ifdef FREQ_GAUGE_SCHED_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= i_writedata[CTRL_IRQEN_BIT];
      if (i_store && i_store_last && |w_tmo_nxt) r_irq <= 1'b1;
      else if (w_clr)                            r_irq <= 1'b0;
    end
  end

  assign o_irq    = r_irq & r_irq_en;
  assign w_unused = &{1'b0, i_writedata[31:3]};
`else
  assign w_unused = &{1'b0, i_writedata[31:2], i_store_last};
`endif

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_RUN_BIT] = r_run;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
    w_ctrl[CTRL_IRQEN_BIT] = r_irq_en;
`endif
  end

  always_comb begin
    w_rdata = '0;
    if (int'(i_address) < NumProbes) w_rdata = r_result[i_address[IW-1:0]];
    else if (i_address == CtrlAddr)  w_rdata = w_ctrl;
    else if (i_address == StatAddr)  w_rdata = {16'(r_tmo), 16'(r_valid)};
  end

  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= i_read ? w_rdata : '0;
  end

  assign o_readdata = r_readdata;
  assign o_run      = r_run;

endmodule

// File: rtl/freq_gauge_scheduler.sv
// Round-robin sequencer time-sharing one frequency-gauge core across NumProbes clocks.
// Optional feature macro: FREQ_GAUGE_SCHED_IRQ_EN (adds irq output).
module freq_gauge_scheduler
  import freq_gauge_sched_pkg::*;
#(
  parameter int NumProbes     = 4,
  parameter int SettleCycles  = 16,
  parameter int TimeoutCycles = 25000000,
  localparam int AW = $clog2(NumProbes + 2),
  localparam int IW = cnt_w(NumProbes)
)(
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
  output logic          irq,
`endif
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] mm_address,
  input  logic          mm_read,
  output logic [31:0]   mm_readdata,
  input  logic          mm_write,
  input  logic [31:0]   mm_writedata,
  output logic [IW-1:0] probe_sel,
  output logic          meas_start,
  input  logic          meas_done,
  input  logic [31:0]   meas_count
);

  localparam int SW = cnt_w(SettleCycles);
  localparam int TW = cnt_w(TimeoutCycles);

  state_e        r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_probe_sel;
  logic [SW-1:0] r_settle_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_meas_start;
  logic          r_ok;
  logic [31:0]   r_count;
  logic          w_run;
  logic          w_last;

  assign w_last = (r_idx == IW'(NumProbes - 1));

  // meas_start is registered out of START so it is seen in the first WAIT cycle (count 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_probe_sel  <= '0;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_meas_start <= 1'b0;
      r_ok         <= 1'b0;
      r_count      <= '0;
    end else begin
      r_meas_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_run) begin
            r_probe_sel <= r_idx;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          r_settle_cnt <= '0;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt == SW'(SettleCycles - 1)) r_state <= START;
          else r_settle_cnt <= r_settle_cnt + 1'b1;
        end
        START: begin
          r_meas_start <= 1'b1;
          r_tmo_cnt    <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (meas_done) begin
            r_count <= meas_count;
            r_ok    <= 1'b1;
            r_state <= STORE;
          end else if (r_tmo_cnt == TW'(TimeoutCycles - 1)) begin
            r_ok    <= 1'b0;
            r_state <= STORE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        STORE: begin
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign probe_sel  = r_probe_sel;
  assign meas_start = r_meas_start;

  freq_gauge_sched_regs #(.NumProbes(NumProbes)) u_regs (
    .clk           (clk),
    .reset         (reset),
    .i_address     (mm_address),
    .i_read        (mm_read),
    .o_readdata    (mm_readdata),
    .i_write       (mm_write),
    .i_writedata   (mm_writedata),
    .i_store       (r_state == STORE),
    .i_store_ok    (r_ok),
    .i_store_last  (w_last),
    .i_store_idx   (r_idx),
    .i_store_count (r_count),
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
    .o_irq         (irq),
`endif
    .o_run         (w_run)
  );

endmodule

// File: tb/tb_freq_gauge_scheduler.sv
// Scoreboard bench for freq_gauge_scheduler with a behavioural gauge-core model.
// Optional feature macro: FREQ_GAUGE_SCHED_IRQ_EN (enables the irq checks).
module tb_freq_gauge_scheduler;

  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 100;
  localparam logic [31:0] BaseHz = 32'd106383400;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
  localparam logic [31:0] IrqEnB = 32'h4;
`else
  localparam logic [31:0] IrqEnB = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  mm_address;
  logic        mm_read;
  logic [31:0] mm_readdata;
  logic        mm_write;
  logic [31:0] mm_writedata;
  logic [1:0]  probe_sel;
  logic        meas_start;
  logic        meas_done;
  logic [31:0] meas_count;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
  logic        irq;
`endif

  freq_gauge_scheduler #(.NumProbes(N), .SettleCycles(S), .TimeoutCycles(T)) dut (
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
    .irq          (irq),
`endif
    .clk          (clk),
    .reset        (reset),
    .mm_address   (mm_address),
    .mm_read      (mm_read),
    .mm_readdata  (mm_readdata),
    .mm_write     (mm_write),
    .mm_writedata (mm_writedata),
    .probe_sel    (probe_sel),
    .meas_start   (meas_start),
    .meas_done    (meas_done),
    .meas_count   (meas_count)
  );

  typedef struct {
    int sel;
    int dly;
    int cyc;
  } st_ev_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          sel_chg = 0;
  int          dly_tab [N];
  logic [N-1:0] mute;
  int          spur_probe;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  st_ev_t      st_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic mm_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    mm_address = a;
    mm_read    = 1'b1;
    @(negedge clk);
    mm_read = 1'b0;
  endtask

  task automatic mm_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    mm_address   = a;
    mm_writedata = d;
    mm_write     = 1'b1;
    @(negedge clk);
    mm_write = 1'b0;
  endtask

  task automatic pop_start(input int exp_sel, input string tag, output st_ev_t ev);
    int n;
    n = 0;
    while (st_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (st_q.size() == 0) begin
      chk(tag, 32'hFFFF_FFFF, exp_sel);
      ev = '{-1, -1, cyc};
    end else begin
      ev = st_q.pop_front();
      chk(tag, ev.sel, exp_sel);
    end
  endtask

  // Read-data side of the scoreboard: one word due the cycle after each read strobe.
  initial begin
    logic        was;
    logic [31:0] e;
    string       t;
    forever begin
      @(posedge clk);
      was = mm_read && !reset;
      #1;
      if (was && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, mm_readdata, e);
      end
    end
  end

  initial begin
    int prev_sel;
    prev_sel = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (int'(probe_sel) != prev_sel) begin
        sel_chg  = cyc;
        prev_sel = int'(probe_sel);
      end
      if (meas_start && !reset) st_q.push_back('{int'(probe_sel), cyc - sel_chg, cyc});
    end
  end

  // Gauge-core model: answers dly_tab[p] cycles after meas_start unless muted or reset.
  initial begin
    meas_done  = 1'b0;
    meas_count = '0;
    forever begin
      @(negedge clk);
      if (meas_start && !reset) begin
        int p;
        int d;
        bit ab;
        p  = int'(probe_sel);
        d  = dly_tab[p];
        ab = 1'b0;
        if (!mute[p]) begin
          for (int k = 0; k < d && !ab; k++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
          end
          if (!ab) begin
            meas_done  = 1'b1;
            meas_count = BaseHz + 32'(p);
            @(negedge clk);
            meas_done = 1'b0;
            if (p == spur_probe) begin
              repeat (4) @(negedge clk);
              meas_done  = 1'b1;
              meas_count = 32'hDEAD_BEEF;
              @(negedge clk);
              meas_done = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    st_ev_t ev;
    int     c2;
    reset        = 1'b1;
    mm_read      = 1'b0;
    mm_write     = 1'b0;
    mm_address   = '0;
    mm_writedata = '0;
    for (int i = 0; i < N; i++) dly_tab[i] = 20;
    mute       = '0;
    spur_probe = -1;

    repeat (3) @(negedge clk);
    chk("rst_meas_start", meas_start, 0);
    chk("rst_probe_sel", probe_sel, 0);
    chk("rst_readdata", mm_readdata, 0);
    reset = 1'b0;
    mm_wr(3'd0, 32'h1234_5678);
    for (int i = 0; i < N; i++) mm_rd(3'(i), 0, "rst_result");
    mm_rd(3'd4, 32'h1, "rst_ctrl");
    mm_rd(3'd5, 32'h0, "rst_status");
    mm_rd(3'd6, 32'h0, "unmapped6");

    // Sweep 1: every probe answers after 20 cycles.
    pop_start(0, "s1_sel0", ev);
    pop_start(1, "s1_sel1", ev);
    chk("s1_settle_to_start", ev.dly, 6);
    c2 = ev.cyc;
    pop_start(2, "s1_sel2", ev);
    chk("s1_probe_period", ev.cyc - c2, 29);
    pop_start(3, "s1_sel3", ev);
    pop_start(0, "s1_wrap0", ev);
    mm_wr(3'd4, 32'h0);
    repeat (130) @(negedge clk);
    chk("s1_idle_no_start", st_q.size(), 0);
    for (int i = 0; i < N; i++) mm_rd(3'(i), BaseHz + 32'(i), "s1_result");
    mm_rd(3'd5, 32'h0000_000F, "s1_status");
    mm_rd(3'd4, 32'h0, "s1_ctrl");

    // Sweep 2: probe 2 never answers.
    mute = 4'b0100;
    mm_wr(3'd4, 32'h1 | IrqEnB);
    pop_start(1, "s2_resume_sel1", ev);
    chk("s2_settle_to_start", ev.dly, 6);
    pop_start(2, "s2_sel2", ev);
    c2 = ev.cyc;
    pop_start(3, "s2_sel3", ev);
    chk("s2_timeout_period", ev.cyc - c2, 108);
    pop_start(0, "s2_wrap0", ev);
    mm_wr(3'd4, IrqEnB);
    repeat (130) @(negedge clk);
    chk("s2_idle_no_start", st_q.size(), 0);
    mm_rd(3'd2, 32'h0, "s2_result2");
    mm_rd(3'd3, BaseHz + 32'd3, "s2_result3");
    mm_rd(3'd5, 32'h0004_000B, "s2_status");
    mm_rd(3'd4, IrqEnB, "s2_ctrl");
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
    chk("s2_irq_set", irq, 1);
`endif

    // Sweep 3: probe 2 answers on the last timeout cycle, then a stray done hits SETTLE.
    mute         = '0;
    dly_tab[2]   = T - 1;
    spur_probe   = 2;
    mm_wr(3'd4, 32'h1);
    pop_start(1, "s3_sel1", ev);
    pop_start(2, "s3_sel2", ev);
    c2 = ev.cyc;
    pop_start(3, "s3_sel3", ev);
    chk("s3_limit_done_period", ev.cyc - c2, 108);
    c2 = ev.cyc;
    pop_start(0, "s3_wrap0", ev);
    chk("s3_after_stray_period", ev.cyc - c2, 29);
    mm_wr(3'd4, 32'h0);
    repeat (130) @(negedge clk);
    chk("s3_idle_no_start", st_q.size(), 0);
    for (int i = 0; i < N; i++) mm_rd(3'(i), BaseHz + 32'(i), "s3_result");
    mm_rd(3'd5, 32'h0000_000F, "s3_status");

    // Clear status, then drop run while probe 1 is in WAIT.
    dly_tab[2] = 20;
    spur_probe = -1;
`ifdef FREQ_GAUGE_SCHED_IRQ_EN
    mm_wr(3'd4, 32'h4);
    chk("irq_pending", irq, 1);
    mm_wr(3'd4, 32'h6);
    chk("irq_cleared", irq, 0);
`endif
    mm_wr(3'd4, 32'h2);
    mm_rd(3'd5, 32'h0, "s4_cleared_status");
    mm_rd(3'd4, 32'h0, "s4_ctrl");
    mm_wr(3'd4, 32'h1);
    pop_start(1, "s4_sel1", ev);
    mm_wr(3'd4, 32'h0);
    repeat (130) @(negedge clk);
    chk("s4_stop_no_start", st_q.size(), 0);
    mm_rd(3'd5, 32'h0000_0002, "s4_status");
    mm_rd(3'd1, BaseHz + 32'd1, "s4_result1");
    mm_wr(3'd4, 32'h1);
    pop_start(2, "s4_resume_sel2", ev);

    // Reset in the middle of WAIT.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_meas_start", meas_start, 0);
    chk("midrst_probe_sel", probe_sel, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mm_rd(3'(i), 0, "midrst_result");
    mm_rd(3'd5, 32'h0, "midrst_status");
    mm_rd(3'd4, 32'h1, "midrst_ctrl");
    mm_rd(3'd7, 32'h0, "unmapped7");

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
